// File: rtl/bcd_down_timer_if.sv
// Control and status bundle for the BCD countdown timer.
interface bcd_down_timer_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned W = 4 * DIGITS;

  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic [W-1:0] counter;
  logic         running;
  logic         done;
  logic         tc_pulse;
  logic         load_err;

  // Controller side: issues requests, observes count and flags.
  modport master (
    output load, load_value, start, pause,
    input  counter, running, done, tc_pulse, load_err
  );

  // Timer side: consumes requests, produces count and flags.
  modport slave (
    input  load, load_value, start, pause,
    output counter, running, done, tc_pulse, load_err
  );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load, start/pause control,
// prescaled decrement rate and a one-cycle terminal-count pulse.
module bcd_down_timer #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 1
) (
  input logic             clk,
  input logic             reset,
  bcd_down_timer_if.slave bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [W-1:0]  count_q,   count_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic          tc_q,      tc_d;
  logic          err_q,     err_d;
  logic          running_q, running_d;
  logic          done_q,    done_d;
  logic [W-1:0]  dec_value;

  // True when every digit of v is a legal BCD digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // BCD minus one: a zero digit becomes 9 and borrows from the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Next-state and next-output logic; load outranks every state action.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    tc_d      = 1'b0;
    err_d     = err_q;
    dec_value = bcd_dec(count_q);

    if (bus.load) begin
      if (bcd_valid(bus.load_value)) begin
        count_d = bus.load_value;
        err_d   = 1'b0;
        state_d = S_IDLE;
        presc_d = '0;
      end else begin
        // Malformed preset: keep count and state, only flag it.
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.pause) begin
            if (count_q == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d = '0;
            count_d = dec_value;
            if (dec_value == '0) begin
              state_d = S_DONE;
              tc_d    = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (bus.start && !bus.pause) state_d = S_RUN;
        end
        default: begin
          // DONE holds until a load or reset.
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      tc_q      <= 1'b0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      tc_q      <= tc_d;
      err_q     <= err_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.counter  = count_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.tc_pulse = tc_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: two instances (prescale 1 and 4) share one
// stimulus stream and are compared against an integer-valued model.
module tb_bcd_down_timer;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;

  int vectors     = 0;
  int miscompares = 0;

  // Model state per instance: count as a plain integer 0..99.
  int m_cnt   [2];
  int m_st    [2];
  int m_presc [2];
  bit m_tc    [2];
  bit m_err   [2];
  int m_ps    [2];

  bcd_down_timer_if #(.DIGITS(2)) bus0 ();
  bcd_down_timer_if #(.DIGITS(2)) bus1 ();

  assign bus0.load       = load;
  assign bus0.load_value = load_value;
  assign bus0.start      = start;
  assign bus0.pause      = pause;
  assign bus1.load       = load;
  assign bus1.load_value = load_value;
  assign bus1.start      = start;
  assign bus1.pause      = pause;

  bcd_down_timer #(.DIGITS(2), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  bcd_down_timer #(.DIGITS(2), .PRESCALE(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int bcd_to_int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_st[u] = ST_IDLE; m_presc[u] = 0;
      m_tc[u] = 1'b0; m_err[u] = 1'b0;
    end
  endtask

  // One clock edge of behaviour for instance u, given the sampled inputs.
  task automatic model_step(input int u);
    m_tc[u] = 1'b0;
    if (load) begin
      if (bcd_ok(load_value)) begin
        m_cnt[u] = bcd_to_int(load_value);
        m_err[u] = 1'b0; m_st[u] = ST_IDLE; m_presc[u] = 0;
      end else begin
        m_err[u] = 1'b1;
      end
    end else if (m_st[u] == ST_IDLE) begin
      if (start && !pause) begin
        if (m_cnt[u] == 0) m_st[u] = ST_DONE;
        else begin m_st[u] = ST_RUN; m_presc[u] = 0; end
      end
    end else if (m_st[u] == ST_RUN) begin
      if (pause) m_st[u] = ST_PAUSE;
      else begin
        m_presc[u]++;
        if (m_presc[u] == m_ps[u]) begin
          m_presc[u] = 0;
          m_cnt[u]--;
          if (m_cnt[u] == 0) begin m_st[u] = ST_DONE; m_tc[u] = 1'b1; end
        end
      end
    end else if (m_st[u] == ST_PAUSE) begin
      if (start && !pause) m_st[u] = ST_RUN;
    end
  endtask

  task automatic check(input int u, input string tag);
    logic [11:0] obs, exp;
    if (u == 0) obs = {bus0.counter, bus0.running, bus0.done, bus0.tc_pulse, bus0.load_err};
    else        obs = {bus1.counter, bus1.running, bus1.done, bus1.tc_pulse, bus1.load_err};
    exp = {int_to_bcd(m_cnt[u]), m_st[u] == ST_RUN, m_st[u] == ST_DONE, m_tc[u], m_err[u]};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed cnt=%h run/done/tc/err=%b required cnt=%h run/done/tc/err=%b",
             tag, u, obs[11:4], obs[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  // Advance one edge, update the model, and compare both instances.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else begin model_step(0); model_step(1); end
    #1;
    check(0, tag);
    check(1, tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_load(input logic [7:0] v, input string tag);
    load = 1'b1; load_value = v;
    tick(tag);
    load = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    tick(tag);
    start = 1'b0;
  endtask

  initial begin
    m_ps[0] = 1;
    m_ps[1] = 4;
    reset = 1'b1; load = 1'b0; load_value = 8'h00; start = 1'b0; pause = 1'b0;
    model_reset();
    #12;
    check(0, "reset");
    check(1, "reset");
    @(negedge clk);
    reset = 1'b0;
    tick("idle");

    // Basic countdown from 03.
    do_load(8'h03, "load03");
    pulse_start("start03");
    ticks(14, "run03");

    // Borrow across the tens digit.
    do_load(8'h10, "load10");
    pulse_start("start10");
    ticks(42, "run10");

    // Pause two clocks after start, hold for five, then resume.
    do_load(8'h02, "load02");
    pulse_start("start02");
    ticks(2, "pre_pause");
    pause = 1'b1;
    ticks(5, "paused");
    pause = 1'b0;
    pulse_start("resume");
    ticks(6, "after_resume");

    // Malformed preset while paused at 07, then a valid reload.
    do_load(8'h07, "load07");
    pulse_start("start07");
    pause = 1'b1;
    tick("pause07");
    pause = 1'b0;
    do_load(8'h1A, "bad_load");
    tick("bad_hold");
    do_load(8'h05, "good_load");

    // Start at zero goes straight to DONE with no pulse.
    do_load(8'h00, "load00");
    pulse_start("start00");
    ticks(2, "done00");
    pulse_start("start_in_done");

    // Start and pause together: no move from IDLE, pause wins in RUN.
    do_load(8'h35, "load35");
    start = 1'b1; pause = 1'b1;
    tick("both_idle");
    pause = 1'b0;
    tick("start35");
    pause = 1'b1;
    tick("both_run");
    pause = 1'b0; start = 1'b0;
    pulse_start("resume35");
    tick("run35");
    do_load(8'h09, "abort_load");
    ticks(3, "after_abort");

    // Reset between edges while running at 05.
    do_load(8'h05, "load05r");
    pulse_start("start05r");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check(0, "async_reset");
    check(1, "async_reset");
    tick("reset_hold");
    reset = 1'b0;

    // Randomized control traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check(0, "rand_reset");
        check(1, "rand_reset");
        tick("rand_reset_hold");
        reset = 1'b0;
      end else begin
        load  = (r < 6);
        if ($urandom_range(0, 3) == 0) load_value = 8'($urandom);
        else load_value = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        start = ($urandom_range(0, 3) == 0);
        pause = ($urandom_range(0, 9) == 0);
        tick("random");
      end
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
    tick("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
